// File: rtl/sprite_engine.sv
// Sprite plot/move datapath: scans a 16x16 sprite from the sprite ROM into the
// VGA pixel-write port and animates objects along fixed start->end paths.
module sprite_engine #(
  parameter int unsigned X_SCREEN_PIXELS = 160,
  parameter int unsigned Y_SCREEN_PIXELS = 120,
  parameter int unsigned FRAME_TICKS     = 833333,
  parameter int unsigned BUBBLE_TICKS    = 150000000,
  parameter logic [2:0]  BG_COLOUR       = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        plot_req,
  input  logic        move_req,
  input  logic [10:0] obj_sel,
  output logic        plot_busy,
  output logic        move_busy,
  output logic        bubble_drawn,
  output logic        remove_bubble,
  output logic [11:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, M_ERASE, M_STEP, M_DRAW, M_DRAIN, M_WAIT} state_t;

  state_t      state, state_next;
  logic [3:0]  obj, req_obj;
  logic [8:0]  cnt;
  logic [19:0] wait_cnt;
  logic [27:0] bub_cnt;
  logic        bub_active;
  logic [7:0]  cur_x [11];
  logic [6:0]  cur_y [11];
  logic        valid, plot_go, move_go, accept, at_end_req, at_end_cur, scanning, is_bubble;
  logic        pix_valid, pix_erase, on_screen;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;

  function automatic logic [7:0] start_x(input logic [3:0] i);
    case (i)
      4'd0:                         return 8'd96;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 8'd112;
      4'd7:                         return 8'd72;
      4'd8:                         return 8'd140;
      default:                      return 8'd8;
    endcase
  endfunction

  function automatic logic [6:0] start_y(input logic [3:0] i);
    case (i)
      4'd0:                         return 7'd40;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 7'd16;
      4'd7:                         return 7'd100;
      4'd8:                         return 7'd80;
      default:                      return 7'd96;
    endcase
  endfunction

  function automatic logic [7:0] end_x(input logic [3:0] i);
    case (i)
      4'd0:                         return 8'd96;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 8'd112;
      4'd7:                         return 8'd72;
      4'd8:                         return 8'd40;
      default:                      return 8'd56;
    endcase
  endfunction

  function automatic logic [6:0] end_y(input logic [3:0] i);
    case (i)
      4'd0:                         return 7'd8;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 7'd16;
      4'd7:                         return 7'd60;
      4'd8:                         return 7'd80;
      default:                      return 7'd72;
    endcase
  endfunction

  always_comb begin
    req_obj = '0;
    for (int unsigned i = 0; i < 11; i++)
      if (obj_sel[i]) req_obj = 4'(i);
  end

  assign valid      = $onehot(obj_sel);
  assign plot_go    = (state == IDLE) && plot_req && valid;
  assign move_go    = (state == IDLE) && move_req && !plot_req && valid;
  assign accept     = plot_go || move_go;
  assign at_end_req = (cur_x[req_obj] == end_x(req_obj)) && (cur_y[req_obj] == end_y(req_obj));
  assign at_end_cur = (cur_x[obj] == end_x(obj)) && (cur_y[obj] == end_y(obj));
  assign is_bubble  = (obj >= 4'd1) && (obj <= 4'd5);
  assign scanning   = (state == SCAN) || (state == M_DRAW) || ((state == M_ERASE) && !cnt[8]);

  assign plot_busy  = plot_go || (state == SCAN) || (state == DRAIN);
  assign move_busy  = move_go || (state inside {M_ERASE, M_STEP, M_DRAW, M_DRAIN, M_WAIT});
  assign rom_addr   = {obj, cnt[7:4], cnt[3:0]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (plot_go) state_next = SCAN;
               else if (move_go && !at_end_req) state_next = M_ERASE;
      SCAN:    if (cnt == 9'd255) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      // erase holds one extra cycle so its last pixel leaves the pipeline before the step
      M_ERASE: if (cnt == 9'd256) state_next = M_STEP;
      M_STEP:  state_next = M_DRAW;
      M_DRAW:  if (cnt == 9'd255) state_next = M_DRAIN;
      M_DRAIN: state_next = at_end_cur ? IDLE : M_WAIT;
      M_WAIT:  if (wait_cnt == '0) state_next = M_ERASE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      obj      <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
      for (int unsigned i = 0; i < 11; i++) begin
        cur_x[i] <= start_x(4'(i));
        cur_y[i] <= start_y(4'(i));
      end
    end else begin
      state <= state_next;
      if (accept) obj <= req_obj;
      if (plot_go) begin
        cur_x[req_obj] <= start_x(req_obj);
        cur_y[req_obj] <= start_y(req_obj);
      end
      if (state_next != state) cnt <= '0;
      else if (state inside {SCAN, M_ERASE, M_DRAW}) cnt <= cnt + 9'd1;
      if (state == M_STEP) begin
        if (cur_x[obj] < end_x(obj)) cur_x[obj] <= cur_x[obj] + 8'd1;
        else if (cur_x[obj] > end_x(obj)) cur_x[obj] <= cur_x[obj] - 8'd1;
        if (cur_y[obj] < end_y(obj)) cur_y[obj] <= cur_y[obj] + 7'd1;
        else if (cur_y[obj] > end_y(obj)) cur_y[obj] <= cur_y[obj] - 7'd1;
      end
      if ((state == M_DRAIN) && (state_next == M_WAIT)) wait_cnt <= 20'(FRAME_TICKS - 1);
      else if (state == M_WAIT) wait_cnt <= wait_cnt - 20'd1;
    end
  end

  // Pixel coordinates are delayed one cycle to line up with the registered ROM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_valid <= 1'b0;
      pix_erase <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      pix_valid <= scanning;
      pix_erase <= (state == M_ERASE);
      if (scanning) begin
        pix_x <= {1'b0, cur_x[obj]} + {5'b0, cnt[3:0]};
        pix_y <= {1'b0, cur_y[obj]} + {4'b0, cnt[7:4]};
      end
    end
  end

  assign on_screen  = (pix_x < 9'(X_SCREEN_PIXELS)) && (pix_y < 8'(Y_SCREEN_PIXELS));
  assign vga_x      = pix_x[7:0];
  assign vga_y      = pix_y[6:0];
  assign vga_plot   = pix_valid && on_screen && (pix_erase || !rom_data[3]);
  assign vga_colour = !pix_valid ? '0 : (pix_erase ? BG_COLOUR : rom_data[2:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bubble_drawn  <= 1'b0;
      remove_bubble <= 1'b0;
      bub_cnt       <= '0;
      bub_active    <= 1'b0;
    end else begin
      bubble_drawn  <= (state == DRAIN) && is_bubble;
      remove_bubble <= 1'b0;
      if (accept) begin
        bub_cnt    <= '0;
        bub_active <= 1'b0;
      end else if ((state == DRAIN) && is_bubble) begin
        bub_cnt    <= 28'(BUBBLE_TICKS);
        bub_active <= 1'b1;
      end else if (bub_active) begin
        bub_cnt <= bub_cnt - 28'd1;
        if (bub_cnt == 28'd1) begin
          remove_bubble <= 1'b1;
          bub_active    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: vector table, hand-written timing and
// reset sequences, and random plot/move requests against a path/ROM model.
module tb_sprite_engine;
  localparam int FT = 4;
  localparam int BT = 10;

  logic        clk, resetn, plot_req, move_req;
  logic [10:0] obj_sel;
  logic        plot_busy, move_busy, bubble_drawn, remove_bubble;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int checks = 0;
  int errors = 0;
  int rom_mode = 0;

  int sx[11] = '{96, 112, 112, 112, 112, 112, 8, 72, 140, 8, 8};
  int sy[11] = '{40, 16, 16, 16, 16, 16, 96, 100, 80, 96, 96};
  int ex[11] = '{96, 112, 112, 112, 112, 112, 56, 72, 40, 56, 56};
  int ey[11] = '{8, 16, 16, 16, 16, 16, 72, 60, 80, 72, 72};
  int mcur_x[11], mcur_y[11];

  logic tr_pb[300], tr_bd[300], tr_rb[300];
  int n_pb, n_mb, n_bd, n_rb, n_wr, n_bad, f_k, f_x, f_y, f_c;

  typedef struct {
    logic [10:0] sel;
    logic        p;
    logic        m;
    int          mode;
    int          pb;
    int          mb;
    int          wr;
    int          bd;
  } vec_t;
  vec_t vecs[10];

  sprite_engine #(.FRAME_TICKS(FT), .BUBBLE_TICKS(BT)) dut (
    .clk(clk), .resetn(resetn), .plot_req(plot_req), .move_req(move_req),
    .obj_sel(obj_sel), .plot_busy(plot_busy), .move_busy(move_busy),
    .bubble_drawn(bubble_drawn), .remove_bubble(remove_bubble),
    .rom_addr(rom_addr), .rom_data(rom_data), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rom_fn(input int mode, input logic [11:0] a);
    logic [11:0] h;
    case (mode)
      0:       return 4'b0100;
      1:       return {a[0], a[6:4]};
      default: begin
        h = (a * 12'd37) ^ (a >> 3);
        return h[5:2];
      end
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_mode, rom_addr);

  function automatic int idx_of(input logic [10:0] s);
    int r = 0;
    for (int i = 0; i < 11; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic int model_writes(input int oi, input int mode);
    int n = 0;
    logic [3:0] d;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        d = rom_fn(mode, {4'(oi), 4'(r), 4'(c)});
        if (!d[3] && (sx[oi] + c < 160) && (sy[oi] + r < 120)) n++;
      end
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [10:0] sel, input logic p, input logic m,
                         input int mode, input int win);
    int oi, row, col, px, py;
    logic ok, acc, ew;
    logic [3:0] d;
    ok  = ($countones(sel) == 1);
    oi  = idx_of(sel);
    acc = ok && p;
    if (acc) begin
      mcur_x[oi] = sx[oi];
      mcur_y[oi] = sy[oi];
    end
    n_pb = 0; n_mb = 0; n_bd = 0; n_rb = 0; n_wr = 0; n_bad = 0;
    f_k = -1; f_x = 0; f_y = 0; f_c = 0;
    rom_mode = mode;
    @(posedge clk); #1;
    obj_sel = sel; plot_req = p; move_req = m;
    for (int k = 0; k < win; k++) begin
      @(negedge clk);
      tr_pb[k] = plot_busy; tr_bd[k] = bubble_drawn; tr_rb[k] = remove_bubble;
      n_pb += int'(plot_busy); n_mb += int'(move_busy);
      n_bd += int'(bubble_drawn); n_rb += int'(remove_bubble);
      ew = 1'b0; d = '0; px = 0; py = 0;
      if (acc && k >= 2 && k <= 257) begin
        row = (k - 2) / 16;
        col = (k - 2) % 16;
        d   = rom_fn(mode, {4'(oi), 4'(row), 4'(col)});
        px  = mcur_x[oi] + col;
        py  = mcur_y[oi] + row;
        ew  = !d[3] && (px < 160) && (py < 120);
      end
      if (vga_plot) begin
        n_wr++;
        if (f_k < 0) begin f_k = k; f_x = vga_x; f_y = vga_y; f_c = vga_colour; end
      end
      if (vga_plot !== ew) n_bad++;
      else if (ew && (vga_x !== 8'(px) || vga_y !== 7'(py) || vga_colour !== d[2:0])) n_bad++;
      if (k == 0) begin
        @(posedge clk); #1;
        plot_req = 1'b0; move_req = 1'b0;
      end
    end
  endtask

  task automatic run_broom_move();
    int fall = -1, nw = 0, e_pass = 0, d_pass = 0, last = 0;
    int emin = 255, emax = 0, dmin = 255, dmax = 0, dymin = 255, dymax = 0;
    rom_mode = 0;
    @(posedge clk); #1;
    obj_sel = 11'h100; move_req = 1'b1;
    @(negedge clk);
    check("move_busy_at_accept", move_busy, 1);
    @(posedge clk); #1;
    move_req = 1'b0;
    for (int k = 1; k <= 60000 && fall < 0; k++) begin
      @(negedge clk);
      if (vga_plot) begin
        nw++;
        if (vga_colour == 3'b000) begin
          if (last != 1) begin e_pass++; emin = 255; emax = 0; end
          last = 1;
          if (vga_x < emin) emin = vga_x;
          if (vga_x > emax) emax = vga_x;
        end else begin
          if (last != 2) begin d_pass++; dmin = 255; dmax = 0; dymin = 255; dymax = 0; end
          last = 2;
          if (vga_x < dmin) dmin = vga_x;
          if (vga_x > dmax) dmax = vga_x;
          if (vga_y < dymin) dymin = vga_y;
          if (vga_y > dymax) dymax = vga_y;
        end
      end
      if (!move_busy) fall = k;
    end
    check("move_fall_cycle", fall, 1 + 100 * 515 + 99 * FT);
    check("move_erase_passes", e_pass, 100);
    check("move_draw_passes", d_pass, 100);
    check("move_total_writes", nw, 100 * 512);
    check("last_erase_xmin", emin, 41);
    check("last_erase_xmax", emax, 56);
    check("last_draw_xmin", dmin, 40);
    check("last_draw_xmax", dmax, 55);
    check("last_draw_yrange", {dymin[15:0], dymax[15:0]}, {16'd80, 16'd95});
    mcur_x[8] = ex[8];
    mcur_y[8] = ey[8];
  endtask

  initial begin
    logic [10:0] sel;
    logic p, m, ok, at_end;
    int oi, mode, e_pb, e_mb, e_bd, e_wr, idle_bad;

    vecs[0] = '{11'h002, 1'b1, 1'b0, 0, 258, 0, 256, 1};
    vecs[1] = '{11'h001, 1'b1, 1'b0, 1, 258, 0, 128, 0};
    vecs[2] = '{11'h003, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    vecs[3] = '{11'h000, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    vecs[4] = '{11'h080, 1'b1, 1'b1, 0, 258, 0, 256, 0};
    vecs[5] = '{11'h004, 1'b0, 1'b1, 0, 0, 1, 0, 0};
    vecs[6] = '{11'h400, 1'b1, 1'b0, 1, 258, 0, 128, 0};
    vecs[7] = '{11'h020, 1'b1, 1'b0, 1, 258, 0, 128, 1};
    vecs[8] = '{11'h600, 1'b0, 1'b1, 0, 0, 0, 0, 0};
    vecs[9] = '{11'h010, 1'b0, 1'b1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 11; i++) begin mcur_x[i] = sx[i]; mcur_y[i] = sy[i]; end

    resetn = 1'b0; plot_req = 1'b0; move_req = 1'b0; obj_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {plot_busy, move_busy, bubble_drawn, remove_bubble, rom_addr,
                            vga_x, vga_y, vga_colour, vga_plot}, 0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].sel, vecs[i].p, vecs[i].m, vecs[i].mode, 280);
      check($sformatf("vec%0d_plot_busy_cycles", i), n_pb, vecs[i].pb);
      check($sformatf("vec%0d_move_busy_cycles", i), n_mb, vecs[i].mb);
      check($sformatf("vec%0d_writes", i), n_wr, vecs[i].wr);
      check($sformatf("vec%0d_bad_pixels", i), n_bad, 0);
      check($sformatf("vec%0d_bubble_drawn", i), n_bd, vecs[i].bd);
      check($sformatf("vec%0d_remove_bubble", i), n_rb, vecs[i].bd);
      if (i == 0) begin
        check("hunger_busy_C", tr_pb[0], 1);
        check("hunger_busy_C257", tr_pb[257], 1);
        check("hunger_busy_C258", tr_pb[258], 0);
        check("hunger_bubble_C257", tr_bd[257], 0);
        check("hunger_bubble_C258", tr_bd[258], 1);
        check("hunger_remove_early", tr_rb[257 + BT], 0);
        check("hunger_remove_pulse", tr_rb[258 + BT], 1);
        check("hunger_first_pixel", {f_k[15:0], f_x[15:0], f_y[15:0]}, {16'd2, 16'd112, 16'd16});
      end
    end

    // bubble timer cancelled by a new plot before it expires
    run_req(11'h008, 1'b1, 1'b0, 0, 263);
    check("cancel_bubble_drawn", n_bd, 1);
    run_req(11'h001, 1'b1, 1'b0, 0, 280);
    check("cancel_no_remove", n_rb, 0);

    run_req(11'h100, 1'b1, 1'b0, 0, 280);
    check("broom_plot_bad_pixels", n_bad, 0);
    run_broom_move();

    // reset in the middle of a scan
    rom_mode = 0;
    @(posedge clk); #1;
    obj_sel = 11'h002; plot_req = 1'b1;
    @(posedge clk); #1;
    plot_req = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    check("pre_reset_busy_plot", {plot_busy, vga_plot}, 2'b11);
    resetn = 1'b0;
    #1;
    check("mid_reset_outputs", {plot_busy, move_busy, bubble_drawn, remove_bubble, rom_addr,
                                vga_x, vga_y, vga_colour, vga_plot}, 0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 11; i++) begin mcur_x[i] = sx[i]; mcur_y[i] = sy[i]; end
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (plot_busy || move_busy || vga_plot) idle_bad++;
    end
    check("post_reset_idle", idle_bad, 0);
    run_req(11'h002, 1'b1, 1'b0, 0, 280);
    check("post_reset_first_pixel", {f_k[15:0], f_x[15:0], f_y[15:0]}, {16'd2, 16'd112, 16'd16});
    check("post_reset_bad_pixels", n_bad, 0);
    run_req(11'h100, 1'b0, 1'b1, 0, 10);
    check("broom_pos_after_reset", {f_k[15:0], f_x[15:0], f_y[15:0], f_c[15:0]},
          {16'd2, 16'd140, 16'd80, 16'd0});
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 11; i++) begin mcur_x[i] = sx[i]; mcur_y[i] = sy[i]; end

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) sel = 11'(1 << $urandom_range(0, 10));
      else sel = 11'($urandom);
      p    = 1'($urandom_range(0, 1));
      m    = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      ok   = ($countones(sel) == 1);
      oi   = idx_of(sel);
      at_end = (mcur_x[oi] == ex[oi]) && (mcur_y[oi] == ey[oi]);
      if (ok && m && !p && !at_end) p = 1'b1;
      e_pb = (ok && p) ? 258 : 0;
      e_mb = (ok && m && !p) ? 1 : 0;
      e_bd = (ok && p && oi >= 1 && oi <= 5) ? 1 : 0;
      e_wr = (ok && p) ? model_writes(oi, mode) : 0;
      run_req(sel, p, m, mode, 280);
      check($sformatf("rnd%0d_plot_busy", it), n_pb, e_pb);
      check($sformatf("rnd%0d_move_busy", it), n_mb, e_mb);
      check($sformatf("rnd%0d_writes", it), n_wr, e_wr);
      check($sformatf("rnd%0d_bad_pixels", it), n_bad, 0);
      check($sformatf("rnd%0d_bubble_drawn", it), n_bd, e_bd);
      check($sformatf("rnd%0d_remove_bubble", it), n_rb, e_bd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
